// File: rtl/distrip_pkg.sv
// -----------------------------------------------------------------------------
// distrip_pkg
// Shared types for the distrip array finder:
//   triad_state_e : per-distrip triad emitter state (IDLE, B0, B1, B2, DEAD)
//   TRIAD_LEN     : number of serial bits in one triad (hit, strip, side)
//   cand_t        : candidate presented by the comparator stage to one emitter
// -----------------------------------------------------------------------------
package distrip_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,
    B1   = 3'd2,
    B2   = 3'd3,
    DEAD = 3'd4
  } triad_state_e;

  localparam int TRIAD_LEN = 3;

  typedef struct packed {
    logic hit;    // distrip has a qualified peak this cycle
    logic strip;  // 1 = upper strip of the pair fired
    logic side;   // 1 = left neighbour larger than right neighbour
  } cand_t;

endpackage

// File: rtl/distrip_triad_fsm.sv
// -----------------------------------------------------------------------------
// distrip_triad_fsm
// Serial triad emitter for one distrip. On a candidate in IDLE it latches the
// strip/side bits and shifts out hit(1), strip, side on consecutive cycles,
// then holds off for DEAD_CYCLES cycles before re-arming.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   cand         : candidate from the comparator/TOT stage
//   triad_out    : registered serial triad bit
//   busy         : registered, high in B0, B1, B2 and DEAD
//   cand_lost    : combinational, candidate present while not IDLE
// -----------------------------------------------------------------------------
module distrip_triad_fsm
  import distrip_pkg::*;
#(
  parameter int DEAD_CYCLES = 2
) (
  input  logic  clock,
  input  logic  reset,
  input  cand_t cand,
  output logic  triad_out,
  output logic  busy,
  output logic  cand_lost
);

  // Counter is loaded with DEAD_CYCLES-1 on entry so DEAD lasts DEAD_CYCLES.
  localparam logic [3:0] DEAD_INIT = (DEAD_CYCLES > 0) ? 4'(DEAD_CYCLES - 1) : 4'd0;

  triad_state_e state_q, state_d;
  logic         strip_q, strip_d;
  logic         side_q, side_d;
  logic [3:0]   dead_q, dead_d;
  logic         triad_q, triad_d;
  logic         busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    strip_d = strip_q;
    side_d  = side_q;
    dead_d  = dead_q;
    case (state_q)
      IDLE: begin
        if (cand.hit) begin
          state_d = B0;
          strip_d = cand.strip;
          side_d  = cand.side;
        end
      end
      B0: state_d = B1;
      B1: state_d = B2;
      B2: begin
        if (DEAD_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = DEAD;
          dead_d  = DEAD_INIT;
        end
      end
      DEAD: begin
        if (dead_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          dead_d = dead_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state itself.
    triad_d = 1'b0;
    case (state_d)
      B0:      triad_d = 1'b1;
      B1:      triad_d = strip_d;
      B2:      triad_d = side_d;
      default: triad_d = 1'b0;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      strip_q <= 1'b0;
      side_q  <= 1'b0;
      dead_q  <= 4'd0;
      triad_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      strip_q <= strip_d;
      side_q  <= side_d;
      dead_q  <= dead_d;
      triad_q <= triad_d;
      busy_q  <= busy_d;
    end
  end

  assign triad_out = triad_q;
  assign busy      = busy_q;
  // busy_q mirrors state_q != IDLE.
  assign cand_lost = cand.hit & busy_q;

endmodule

// File: rtl/distrip_array_finder.sv
// -----------------------------------------------------------------------------
// distrip_array_finder
// Peak finder for NDISTRIP adjacent distrips (2*NDISTRIP strips). Each strip
// gets a registered local-peak/side decision and a time-over-threshold window;
// each distrip drives one serial triad emitter.
// Ports:
//   clock, reset             : system clock, synchronous active-high reset
//   q                        : strip samples, strip i at q[i*ADCW +: ADCW]
//   q_left_edge/q_right_edge : neighbour samples beyond strip 0 / strip NS-1
//   vth                      : threshold, strict unsigned q > vth
//   tot_bypass               : forces TOT window bit k true (bit 0 newest)
//   enable_mask              : per-distrip trigger enable
//   triad_out, busy          : per-distrip serial triad and busy flag
//   drop_count               : saturating lost-hit counter
// Build option: define DISTRIP_DROP_COUNT_EN to build the drop counter;
// otherwise drop_count is tied to zero.
// -----------------------------------------------------------------------------
module distrip_array_finder
  import distrip_pkg::*;
#(
  parameter int NDISTRIP    = 8,
  parameter int ADCW        = 10,
  parameter int TOT_LEN     = 6,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2*NDISTRIP*ADCW-1:0]   q,
  input  logic [ADCW-1:0]              q_left_edge,
  input  logic [ADCW-1:0]              q_right_edge,
  input  logic [ADCW-1:0]              vth,
  input  logic [TOT_LEN-1:0]           tot_bypass,
  input  logic [NDISTRIP-1:0]          enable_mask,
  output logic [NDISTRIP-1:0]          triad_out,
  output logic [NDISTRIP-1:0]          busy,
  output logic [15:0]                  drop_count
);

  localparam int NS = 2 * NDISTRIP;

  // Samples extended with the edge neighbours: qx[i+1] is strip i.
  logic [ADCW-1:0]    qx [NS+2];

  logic [NS-1:0]      peak_q, peak_d;
  logic [NS-1:0]      side_q, side_d;
  logic [TOT_LEN-1:0] sr_q [NS];
  logic [TOT_LEN-1:0] sr_d [NS];
  logic [NS-1:0]      tot_ok;
  logic [NDISTRIP-1:0] lost;

  always_comb begin
    qx[0]    = q_left_edge;
    qx[NS+1] = q_right_edge;
    for (int i = 0; i < NS; i++) begin
      qx[i+1] = q[i*ADCW +: ADCW];
    end
  end

  // Strict compare on the left, non-strict on the right: of two equal
  // neighbours only the left one can be a peak.
  always_comb begin
    peak_d = '0;
    side_d = '0;
    for (int i = 0; i < NS; i++) begin
      peak_d[i] = (qx[i+1] > qx[i]) && (qx[i+1] >= qx[i+2]);
      side_d[i] = (qx[i] > qx[i+2]);
      sr_d[i]   = (sr_q[i] << 1) | TOT_LEN'(qx[i+1] > vth);
    end
  end

  always_comb begin
    tot_ok = '0;
    for (int i = 0; i < NS; i++) begin
      tot_ok[i] = &(sr_q[i] | tot_bypass);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      peak_q <= '0;
      side_q <= '0;
      for (int i = 0; i < NS; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      peak_q <= peak_d;
      side_q <= side_d;
      for (int i = 0; i < NS; i++) begin
        sr_q[i] <= sr_d[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NDISTRIP; gi++) begin : g_distrip
      logic  fire_lo;
      logic  fire_hi;
      cand_t cand;

      assign fire_lo = peak_q[2*gi]   & tot_ok[2*gi];
      assign fire_hi = peak_q[2*gi+1] & tot_ok[2*gi+1];

      // Adjacent strips are never both peaks, so at most one of the pair fires.
      always_comb begin
        cand.hit   = enable_mask[gi] & (fire_lo | fire_hi);
        cand.strip = fire_hi;
        cand.side  = fire_hi ? side_q[2*gi+1] : side_q[2*gi];
      end

      distrip_triad_fsm #(
        .DEAD_CYCLES (DEAD_CYCLES)
      ) u_fsm (
        .clock     (clock),
        .reset     (reset),
        .cand      (cand),
        .triad_out (triad_out[gi]),
        .busy      (busy[gi]),
        .cand_lost (lost[gi])
      );
    end
  endgenerate

`ifdef DISTRIP_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if ((|lost) && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= 16'd0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  logic unused_lost;
  assign unused_lost = |lost;
  assign drop_count  = 16'd0;
`endif

endmodule

// File: tb/tb_distrip_array_finder.sv
// -----------------------------------------------------------------------------
// tb_distrip_array_finder
// Directed-vector bench for distrip_array_finder at default parameters.
// Expected triad/busy sequences are given per cycle as strings, leftmost
// character = first cycle after reset release.
// -----------------------------------------------------------------------------
module tb_distrip_array_finder;

  localparam int NDISTRIP = 8;
  localparam int ADCW     = 10;
  localparam int TOT_LEN  = 6;
  localparam int NS       = 2 * NDISTRIP;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NS*ADCW-1:0]   q;
  logic [ADCW-1:0]      q_left_edge;
  logic [ADCW-1:0]      q_right_edge;
  logic [ADCW-1:0]      vth;
  logic [TOT_LEN-1:0]   tot_bypass;
  logic [NDISTRIP-1:0]  enable_mask;
  logic [NDISTRIP-1:0]  triad_out;
  logic [NDISTRIP-1:0]  busy;
  logic [15:0]          drop_count;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clock = ~clock;

  distrip_array_finder dut (
    .clock        (clock),
    .reset        (reset),
    .q            (q),
    .q_left_edge  (q_left_edge),
    .q_right_edge (q_right_edge),
    .vth          (vth),
    .tot_bypass   (tot_bypass),
    .enable_mask  (enable_mask),
    .triad_out    (triad_out),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_strip(input int i, input int v);
    q[i*ADCW +: ADCW] = v[ADCW-1:0];
  endtask

  task automatic clear_samples();
    q            = '0;
    q_left_edge  = '0;
    q_right_edge = '0;
  endtask

  task automatic do_reset(input string tag);
    reset       = 1'b1;
    clear_samples();
    vth         = 10'd80;
    tot_bypass  = '0;
    enable_mask = '1;
    tick();
    tick();
    check_eq({tag, " rst triad"}, 32'(triad_out), 32'd0);
    check_eq({tag, " rst busy"}, 32'(busy), 32'd0);
    check_eq({tag, " rst drop"}, 32'(drop_count), 32'd0);
    reset = 1'b0;
  endtask

  // Runs len(tri_s) cycles; samples are cleared before the edge following
  // cycle 'hold'. Only distrip d may show activity.
  task automatic run_check(input string tag, input int d, input int hold,
                           input string tri_s, input string busy_s);
    logic [31:0] exp_t;
    logic [31:0] exp_b;
    for (int t = 1; t <= tri_s.len(); t++) begin
      if (t == hold + 1) clear_samples();
      tick();
      exp_t = (tri_s.getc(t-1) == "1") ? (32'd1 << d) : 32'd0;
      exp_b = (busy_s.getc(t-1) == "1") ? (32'd1 << d) : 32'd0;
      check_eq($sformatf("%s triad t%0d", tag, t), 32'(triad_out), exp_t);
      check_eq($sformatf("%s busy t%0d", tag, t), 32'(busy), exp_b);
    end
    $display("scenario %s: %0d cycles, errors so far %0d", tag, tri_s.len(), err_cnt);
  endtask

  task automatic stim_peak();
    set_strip(4, 100);
    set_strip(5, 200);
    set_strip(6, 50);
  endtask

  initial begin
    int exp_drop;

    // Single upper-strip peak, side 1 (100 > 50): triad 1,1,1 then period 6.
    do_reset("peak");
    stim_peak();
    run_check("peak", 2, 12, "000000111000111000", "000000111110111110");

    // Same peak with distrip 2 disabled: nothing.
    do_reset("mask");
    enable_mask = 8'hFB;
    stim_peak();
    run_check("mask", 2, 12, "000000000000", "000000000000");

    // Only 5 cycles above threshold: window never fills.
    do_reset("tot_short");
    set_strip(4, 60);
    set_strip(5, 200);
    set_strip(6, 50);
    run_check("tot_short", 2, 5, "0000000000", "0000000000");

    // Oldest window bit bypassed: 5 cycles suffice, triad 1,1,1.
    do_reset("tot_byp");
    tot_bypass = 6'b100000;
    set_strip(4, 60);
    set_strip(5, 200);
    set_strip(6, 50);
    run_check("tot_byp", 2, 5, "0000011100", "0000011111");

    // Tie between strips 4 and 5: lower strip wins, side 0.
    do_reset("tie");
    set_strip(3, 10);
    set_strip(4, 200);
    set_strip(5, 200);
    run_check("tie", 2, 9, "00000010000", "00000011111");

    // Edge strip 0 against q_left_edge.
    do_reset("edge");
    set_strip(0, 300);
    set_strip(1, 100);
    q_left_edge = 10'd50;
    run_check("edge", 0, 9, "000000100", "000000111");

    do_reset("edge_blk");
    set_strip(0, 300);
    set_strip(1, 100);
    q_left_edge = 10'd400;
    run_check("edge_blk", 0, 9, "000000000", "000000000");

    // Reset while in B1 aborts; TOT window refills before the next hit.
    do_reset("rst_mid");
    stim_peak();
    for (int t = 1; t <= 8; t++) tick();
    check_eq("rst_mid b1 triad", 32'(triad_out), 32'h4);
    reset = 1'b1;
    tick();
    check_eq("rst_mid abort triad", 32'(triad_out), 32'd0);
    check_eq("rst_mid abort busy", 32'(busy), 32'd0);
    reset = 1'b0;
    for (int t = 10; t <= 15; t++) begin
      tick();
      check_eq($sformatf("rst_mid refill triad t%0d", t), 32'(triad_out), 32'd0);
    end
    tick();
    check_eq("rst_mid retrigger triad", 32'(triad_out), 32'h4);
    check_eq("rst_mid retrigger busy", 32'(busy), 32'h4);
    $display("scenario rst_mid: errors so far %0d", err_cnt);

    // Peak held 30 cycles: candidate in cycles 6..30, idle in 6,12,18,24,30.
    do_reset("drop");
    stim_peak();
    for (int t = 1; t <= 32; t++) begin
      if (t == 31) clear_samples();
      tick();
    end
`ifdef DISTRIP_DROP_COUNT_EN
    exp_drop = 20;
`else
    exp_drop = 0;
`endif
    check_eq("drop count", 32'(drop_count), 32'(exp_drop));
    $display("scenario drop: drop_count=%0d, errors so far %0d", drop_count, err_cnt);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
